// File: rtl/bram_rr_arbiter_pkg.sv
// Shared types and helpers for the round-robin BRAM arbiter.
// Latency: n/a (types only); backpressure: n/a.
package bram_arb_pkg;

    localparam int BRAM_DEFAULT_LATENCY = 3;
    localparam int MAX_ID_W             = 3;

    // Requester ID width; a single requester bit still needs one ID bit.
    function automatic int id_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    typedef struct packed {
        logic                vld;
        logic [MAX_ID_W-1:0] id;
    } trk_entry_t;

endpackage

// File: rtl/bram_rr_arbiter_if.sv
// Requester-side bundle of the BRAM arbiter: packed per-requester request lanes plus grant/return.
// Latency: n/a (wiring only); backpressure: req is held until gnt.
interface bram_rr_arbiter_if #(
    parameter int NUM_REQ    = 4,
    parameter int ADDR_WIDTH = 15,
    parameter int DATA_WIDTH = 32
);
    logic [NUM_REQ-1:0]            req;
    logic [NUM_REQ-1:0]            we;
    logic [NUM_REQ*ADDR_WIDTH-1:0] addr;
    logic [NUM_REQ*DATA_WIDTH-1:0] din;
    logic [NUM_REQ-1:0]            gnt;
    logic [NUM_REQ-1:0]            rvalid;
    logic [DATA_WIDTH-1:0]         rdata;
    logic                          busy;

    modport master (
        output req, we, addr, din,
        input  gnt, rvalid, rdata, busy
    );

    modport slave (
        input  req, we, addr, din,
        output gnt, rvalid, rdata, busy
    );
endinterface

// File: rtl/bram_rr_arbiter_core.sv
// Combinational round-robin pick: first asserted req scanning upward from ptr, wrapping.
// Latency: 0 cycles; backpressure: none, losers simply see gnt=0.
module rr_arbiter_core #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    ptr,
    output logic [NUM_REQ-1:0] gnt,
    output logic [ID_W-1:0]    win
);

    always_comb begin
        int   idx;
        logic found;
        gnt   = '0;
        win   = '0;
        found = 1'b0;
        idx   = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = int'(ptr) + i;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (!found && req[idx]) begin
                found    = 1'b1;
                gnt[idx] = 1'b1;
                win      = ID_W'(idx);
            end
        end
    end

endmodule

// File: rtl/bram_rr_arbiter.sv
// Shares one single-port BRAM among NUM_REQ requesters, round-robin, one access per cycle.
// Latency: grant same cycle, read return READ_LATENCY cycles later; backpressure: losers hold req.
module bram_rr_arbiter
    import bram_arb_pkg::*;
#(
    parameter int NUM_REQ      = 4,
    parameter int READ_LATENCY = BRAM_DEFAULT_LATENCY,
    parameter int ADDR_WIDTH   = 15,
    parameter int DATA_WIDTH   = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    bram_rr_arbiter_if.slave      bus,
    output logic                  bram_en,
    output logic                  bram_we,
    output logic [ADDR_WIDTH-1:0] bram_addr,
    output logic [DATA_WIDTH-1:0] bram_din,
    input  logic [DATA_WIDTH-1:0] bram_dout
);

    localparam int ID_W = id_width(NUM_REQ);

    logic [ID_W-1:0]    ptr;
    logic [ID_W-1:0]    win;
    logic [NUM_REQ-1:0] req_m;
    logic [NUM_REQ-1:0] gnt;
    logic               granted;
    logic               rd_issue;
    logic [NUM_REQ-1:0] rvalid;
    logic               busy;
    trk_entry_t         pipe [READ_LATENCY];
    trk_entry_t         trk_out;

    // Requests are masked during reset so nothing is granted or driven to the BRAM.
    assign req_m = rst ? '0 : bus.req;

    rr_arbiter_core #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_core (
        .req (req_m),
        .ptr (ptr),
        .gnt (gnt),
        .win (win)
    );

    assign granted  = |gnt;
    assign rd_issue = granted & ~bus.we[win];
    assign bus.gnt  = gnt;

    always_comb begin
        bram_en   = granted;
        bram_we   = 1'b0;
        bram_addr = '0;
        bram_din  = '0;
        if (granted) begin
            bram_we   = bus.we[win];
            bram_addr = bus.addr[int'(win)*ADDR_WIDTH +: ADDR_WIDTH];
            bram_din  = bus.din[int'(win)*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr <= '0;
        end else if (granted) begin
            ptr <= (int'(win) == NUM_REQ - 1) ? '0 : win + 1'b1;
        end
    end

    // Tracking pipeline mirrors the BRAM read latency so the last stage lines up with valid dout.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int s = 0; s < READ_LATENCY; s++) pipe[s] <= '0;
        end else begin
            pipe[0] <= '{vld: rd_issue, id: MAX_ID_W'(win)};
            for (int s = 1; s < READ_LATENCY; s++) pipe[s] <= pipe[s-1];
        end
    end

    assign trk_out = pipe[READ_LATENCY-1];

    always_comb begin
        rvalid = '0;
        busy   = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) rvalid[i] = trk_out.vld && (trk_out.id == MAX_ID_W'(i));
        for (int s = 0; s < READ_LATENCY; s++) busy = busy | pipe[s].vld;
    end

    assign bus.rvalid = rvalid;
    assign bus.rdata  = trk_out.vld ? bram_dout : '0;
    assign bus.busy   = busy;

endmodule
